// File: rtl/ctrl_pipe_pkg.sv
// rtl/ctrl_pipe_pkg.sv - control-word field offsets and encodings for ctrl_pipeline
package ctrl_pipe_pkg;

    localparam int CF_PC_COND = 0;
    localparam int CF_PC_NOT  = 1;
    localparam int CF_PC_SEL  = 2;
    localparam int CF_REG_WE  = 4;
    localparam int CF_IS_LOAD = 5;

    typedef enum logic [1:0] {
        RD_NONE = 2'b00,
        RD_RS1  = 2'b01,
        RD_RS2  = 2'b10,
        RD_BOTH = 2'b11
    } reg_rd_e;

    typedef enum logic [1:0] {
        PC_SEQ  = 2'b00,
        PC_JALR = 2'b01,
        PC_BR   = 2'b11
    } pc_sel_e;

    function automatic logic uses_rs1(input logic [1:0] reg_rd);
        return (reg_rd == RD_RS1) || (reg_rd == RD_BOTH);
    endfunction

    function automatic logic uses_rs2(input logic [1:0] reg_rd);
        return (reg_rd == RD_RS2) || (reg_rd == RD_BOTH);
    endfunction

endpackage

// File: rtl/ctrl_stage_reg.sv
// rtl/ctrl_stage_reg.sv - one pipeline stage register: async reset, sync flush, stall hold, bubble insert
module ctrl_stage_reg #(
    parameter int W = 29
) (
    input  logic         clk,
    input  logic         reset_E,
    input  logic         i_flush,
    input  logic         i_stall,
    input  logic         i_bubble,
    input  logic         i_valid,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    logic         r_valid;
    logic [W-1:0] r_data;

    // Bubble only matters when this stage is not itself holding.
    always_ff @(posedge clk or posedge reset_E) begin
        if (reset_E) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_stall) begin
            r_valid <= r_valid;
            r_data  <= r_data;
        end else if (i_bubble) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            r_valid <= i_valid;
            r_data  <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/ctrl_pipeline.sv
// rtl/ctrl_pipeline.sv - control-word pipeline with branch resolution and RAW hazard detection
// Optional forwarding build: define CTRL_PIPE_FWD_EN.
module ctrl_pipeline
    import ctrl_pipe_pkg::*;
#(
    parameter int NSTAGE = 3,
    parameter int CW     = 24,
    parameter int RW     = 5
) (
    input  logic                 clk,
    input  logic                 reset_E,
    input  logic                 valid_D,
    input  logic [CW-1:0]        ctrl_D,
    input  logic [RW-1:0]        rd_D,
    input  logic [RW-1:0]        rs1_D,
    input  logic [RW-1:0]        rs2_D,
    input  logic [1:0]           reg_rd_D,
    input  logic [NSTAGE-1:0]    stall_i,
    input  logic [NSTAGE-1:0]    flush_i,
    input  logic                 take_i,
    output logic [NSTAGE*CW-1:0] ctrl_o,
    output logic [NSTAGE-1:0]    valid_o,
    output logic [1:0]           pc_sel_o,
    output logic                 redirect_o,
    output logic                 hazard_o,
    output logic [1:0]           fwd1_o,
    output logic [1:0]           fwd2_o
);

    logic [NSTAGE-1:0]         w_valid;
    logic [NSTAGE-1:0][CW-1:0] w_ctrl;
    logic [NSTAGE-1:0][RW-1:0] w_rd;
    logic                      w_redirect;
    logic [CW-1:0]             w_ctrl_s1;
    logic                      w_use1;
    logic                      w_use2;
    logic [NSTAGE-1:0]         w_m1;
    logic [NSTAGE-1:0]         w_m2;

    assign w_redirect = w_valid[0] & w_ctrl[0][CF_PC_COND] & (take_i ^ w_ctrl[0][CF_PC_NOT]);

    // Conditional branches leave stage 0 with their resolved pc_SEL.
    always_comb begin
        w_ctrl_s1 = w_ctrl[0];
        if (w_ctrl[0][CF_PC_COND])
            w_ctrl_s1[CF_PC_SEL +: 2] = w_redirect ? PC_BR : PC_SEQ;
    end

    for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
        logic             w_d_valid;
        logic             w_bubble;
        logic [CW-1:0]    w_d_ctrl;
        logic [RW-1:0]    w_d_rd;
        logic [CW+RW-1:0] w_q;

        if (k == 0) begin : g_first
            assign w_d_valid = valid_D;
            assign w_d_ctrl  = ctrl_D;
            assign w_d_rd    = rd_D;
            assign w_bubble  = 1'b0;
        end else begin : g_rest
            assign w_d_valid = w_valid[k-1];
            assign w_d_ctrl  = (k == 1) ? w_ctrl_s1 : w_ctrl[k-1];
            assign w_d_rd    = w_rd[k-1];
            assign w_bubble  = stall_i[k-1];
        end

        ctrl_stage_reg #(.W(CW + RW)) u_reg (
            .clk      (clk),
            .reset_E  (reset_E),
            .i_flush  (flush_i[k]),
            .i_stall  (stall_i[k]),
            .i_bubble (w_bubble),
            .i_valid  (w_d_valid),
            .i_data   ({w_d_rd, w_d_ctrl}),
            .o_valid  (w_valid[k]),
            .o_data   (w_q)
        );

        assign w_ctrl[k] = w_q[CW-1:0];
        assign w_rd[k]   = w_q[CW +: RW];
    end

    assign w_use1 = valid_D & uses_rs1(reg_rd_D);
    assign w_use2 = valid_D & uses_rs2(reg_rd_D);

    // Per-stage source match against a live writer; x0 is never a dependency.
    always_comb begin
        w_m1 = '0;
        w_m2 = '0;
        for (int k = 0; k < NSTAGE; k++) begin
            w_m1[k] = w_valid[k] & w_ctrl[k][CF_REG_WE] & (w_rd[k] != '0) & w_use1 & (w_rd[k] == rs1_D);
            w_m2[k] = w_valid[k] & w_ctrl[k][CF_REG_WE] & (w_rd[k] != '0) & w_use2 & (w_rd[k] == rs2_D);
        end
    end

`ifdef CTRL_PIPE_FWD_EN
    localparam int FWD_LAST = (NSTAGE > 2) ? 2 : 1;

    assign hazard_o = (w_m1[0] | w_m2[0]) & w_ctrl[0][CF_IS_LOAD];

    // Walk oldest to youngest so the youngest matching writer wins.
    always_comb begin
        fwd1_o = 2'b00;
        fwd2_o = 2'b00;
        for (int k = FWD_LAST; k >= 1; k--) begin
            if (w_m1[k]) fwd1_o = 2'(k);
            if (w_m2[k]) fwd2_o = 2'(k);
        end
    end
`else
    localparam logic [NSTAGE-1:0] HZ_MASK = {1'b0, {(NSTAGE-1){1'b1}}};

    assign hazard_o = |((w_m1 | w_m2) & HZ_MASK);
    assign fwd1_o   = 2'b00;
    assign fwd2_o   = 2'b00;
`endif

    assign ctrl_o     = w_ctrl;
    assign valid_o    = w_valid;
    assign pc_sel_o   = w_ctrl[1][CF_PC_SEL +: 2];
    assign redirect_o = w_redirect;

endmodule

// File: tb/tb_ctrl_pipeline.sv
// tb/tb_ctrl_pipeline.sv - directed self-checking bench for ctrl_pipeline
module tb_ctrl_pipeline;

    localparam int NSTAGE = 3;
    localparam int CW     = 24;
    localparam int RW     = 5;
`ifdef CTRL_PIPE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 reset_E;
    logic                 valid_D;
    logic [CW-1:0]        ctrl_D;
    logic [RW-1:0]        rd_D, rs1_D, rs2_D;
    logic [1:0]           reg_rd_D;
    logic [NSTAGE-1:0]    stall_i, flush_i;
    logic                 take_i;
    logic [NSTAGE*CW-1:0] ctrl_o;
    logic [NSTAGE-1:0]    valid_o;
    logic [1:0]           pc_sel_o, fwd1_o, fwd2_o;
    logic                 redirect_o, hazard_o;

    int n_vec = 0;
    int n_err = 0;

    ctrl_pipeline #(.NSTAGE(NSTAGE), .CW(CW), .RW(RW)) dut (
        .clk(clk), .reset_E(reset_E), .valid_D(valid_D), .ctrl_D(ctrl_D), .rd_D(rd_D),
        .rs1_D(rs1_D), .rs2_D(rs2_D), .reg_rd_D(reg_rd_D), .stall_i(stall_i), .flush_i(flush_i),
        .take_i(take_i), .ctrl_o(ctrl_o), .valid_o(valid_o), .pc_sel_o(pc_sel_o),
        .redirect_o(redirect_o), .hazard_o(hazard_o), .fwd1_o(fwd1_o), .fwd2_o(fwd2_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!reset_E)
            assert ((!stall_i[1] || stall_i[0]) && (!stall_i[2] || stall_i[1]))
                else $error("stall_i not monotone: %b", stall_i);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        valid_D = 0; ctrl_D = '0; rd_D = '0; rs1_D = '0; rs2_D = '0;
        reg_rd_D = 2'b00; stall_i = '0; flush_i = '0; take_i = 0;
    endtask

    task automatic clear_pipe();
        idle();
        flush_i = '1;
        step();
        flush_i = '0;
    endtask

    task automatic test_reset();
        idle();
        reset_E = 1;
        #3;
        n_vec++; if (valid_o !== 3'b000) begin n_err++; $display("FAIL rst_valid got %b exp 000", valid_o); end
        n_vec++; if (ctrl_o !== '0) begin n_err++; $display("FAIL rst_ctrl got %h exp 0", ctrl_o); end
        n_vec++; if (pc_sel_o !== 2'b00) begin n_err++; $display("FAIL rst_pcsel got %b exp 00", pc_sel_o); end
        step();
        step();
        reset_E = 0;
        valid_D = 1; rd_D = 5'd1;
        ctrl_D = 24'h000110; step();
        ctrl_D = 24'h000220; step();
        ctrl_D = 24'h000330; step();
        n_vec++; if (valid_o !== 3'b111) begin n_err++; $display("FAIL fill_valid got %b exp 111", valid_o); end
        n_vec++; if (ctrl_o !== {24'h000110, 24'h000220, 24'h000330}) begin
            n_err++; $display("FAIL fill_ctrl got %h exp %h", ctrl_o, {24'h000110, 24'h000220, 24'h000330}); end
        #2 reset_E = 1;
        #1;
        n_vec++; if (valid_o !== 3'b000) begin n_err++; $display("FAIL midrst_valid got %b exp 000", valid_o); end
        n_vec++; if (ctrl_o !== '0) begin n_err++; $display("FAIL midrst_ctrl got %h exp 0", ctrl_o); end
        step();
        reset_E = 0;
        idle();
    endtask

    task automatic test_branch();
        logic [CW-1:0] br_ctrl [4] = '{24'h000003, 24'h000003, 24'h000001, 24'h000004};
        logic          br_take [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        logic          exp_redir [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [1:0]    exp_sel [4] = '{2'b11, 2'b00, 2'b11, 2'b01};
        for (int i = 0; i < 4; i++) begin
            idle();
            valid_D = 1; ctrl_D = br_ctrl[i];
            step();
            idle();
            take_i = br_take[i];
            #1;
            n_vec++; if (redirect_o !== exp_redir[i]) begin
                n_err++; $display("FAIL br%0d_redirect got %b exp %b", i, redirect_o, exp_redir[i]); end
            step();
            n_vec++; if (pc_sel_o !== exp_sel[i]) begin
                n_err++; $display("FAIL br%0d_pcsel got %b exp %b", i, pc_sel_o, exp_sel[i]); end
            n_vec++; if (ctrl_o[CW +: CW] !== {br_ctrl[i][CW-1:4], exp_sel[i], br_ctrl[i][1:0]}) begin
                n_err++; $display("FAIL br%0d_s1ctrl got %h exp %h", i, ctrl_o[CW +: CW],
                                  {br_ctrl[i][CW-1:4], exp_sel[i], br_ctrl[i][1:0]}); end
        end
        idle();
    endtask

    task automatic test_stall();
        clear_pipe();
        valid_D = 1;
        ctrl_D = 24'h000A00; step();
        ctrl_D = 24'h000B00; step();
        ctrl_D = 24'h000C00; step();
        ctrl_D = 24'h000D00; stall_i = 3'b001;
        step();
        n_vec++; if (valid_o !== 3'b101) begin n_err++; $display("FAIL stall1_valid got %b exp 101", valid_o); end
        n_vec++; if (ctrl_o !== {24'h000B00, 24'h000000, 24'h000C00}) begin
            n_err++; $display("FAIL stall1_ctrl got %h", ctrl_o); end
        step();
        n_vec++; if (valid_o !== 3'b001) begin n_err++; $display("FAIL stall2_valid got %b exp 001", valid_o); end
        n_vec++; if (ctrl_o !== {24'h000000, 24'h000000, 24'h000C00}) begin
            n_err++; $display("FAIL stall2_ctrl got %h", ctrl_o); end
        stall_i = 3'b000;
        step();
        n_vec++; if (valid_o !== 3'b011) begin n_err++; $display("FAIL unstall_valid got %b exp 011", valid_o); end
        n_vec++; if (ctrl_o !== {24'h000000, 24'h000C00, 24'h000D00}) begin
            n_err++; $display("FAIL unstall_ctrl got %h", ctrl_o); end
    endtask

    task automatic test_flush_stall();
        stall_i = 3'b001; flush_i = 3'b001;
        step();
        idle();
        n_vec++; if (valid_o !== 3'b100) begin n_err++; $display("FAIL flst_valid got %b exp 100", valid_o); end
        n_vec++; if (ctrl_o !== {24'h000C00, 24'h000000, 24'h000000}) begin
            n_err++; $display("FAIL flst_ctrl got %h", ctrl_o); end
    endtask

    task automatic test_load_use();
        clear_pipe();
        valid_D = 1; ctrl_D = 24'h000030; rd_D = 5'd5;
        step();
        ctrl_D = 24'h000010; rd_D = 5'd7; rs1_D = 5'd5; reg_rd_D = 2'b01; flush_i = 3'b001;
        #1;
        n_vec++; if (hazard_o !== 1'b1) begin n_err++; $display("FAIL lu_s0_hazard got %b exp 1", hazard_o); end
        n_vec++; if (fwd1_o !== 2'd0) begin n_err++; $display("FAIL lu_s0_fwd1 got %0d exp 0", fwd1_o); end
        step();
        flush_i = 3'b000;
        #1;
        n_vec++; if (hazard_o !== !FWD) begin n_err++; $display("FAIL lu_s1_hazard got %b exp %b", hazard_o, !FWD); end
        n_vec++; if (fwd1_o !== (FWD ? 2'd1 : 2'd0)) begin
            n_err++; $display("FAIL lu_s1_fwd1 got %0d exp %0d", fwd1_o, FWD ? 1 : 0); end
        flush_i = 3'b001;
        step();
        flush_i = 3'b000;
        #1;
        n_vec++; if (hazard_o !== 1'b0) begin n_err++; $display("FAIL lu_s2_hazard got %b exp 0", hazard_o); end
        n_vec++; if (fwd1_o !== (FWD ? 2'd2 : 2'd0)) begin
            n_err++; $display("FAIL lu_s2_fwd1 got %0d exp %0d", fwd1_o, FWD ? 2 : 0); end
        rs1_D = 5'd0; rs2_D = 5'd5; reg_rd_D = 2'b10;
        #1;
        n_vec++; if (fwd2_o !== (FWD ? 2'd2 : 2'd0)) begin
            n_err++; $display("FAIL lu_s2_fwd2 got %0d exp %0d", fwd2_o, FWD ? 2 : 0); end
        n_vec++; if (fwd1_o !== 2'd0) begin n_err++; $display("FAIL lu_s2_fwd1_rs2 got %0d exp 0", fwd1_o); end
        reg_rd_D = 2'b00;
        #1;
        n_vec++; if (fwd2_o !== 2'd0) begin n_err++; $display("FAIL lu_none_fwd2 got %0d exp 0", fwd2_o); end
        idle();
    endtask

    task automatic test_back_to_back();
        clear_pipe();
        valid_D = 1; ctrl_D = 24'h000010; rd_D = 5'd6;
        step();
        step();
        ctrl_D = 24'h000010; rd_D = 5'd9; rs2_D = 5'd6; reg_rd_D = 2'b10;
        #1;
        n_vec++; if (hazard_o !== !FWD) begin n_err++; $display("FAIL b2b_s0_hazard got %b exp %b", hazard_o, !FWD); end
        n_vec++; if (fwd2_o !== (FWD ? 2'd1 : 2'd0)) begin
            n_err++; $display("FAIL b2b_s0_fwd2 got %0d exp %0d", fwd2_o, FWD ? 1 : 0); end
        flush_i = 3'b001;
        step();
        flush_i = 3'b000;
        #1;
        n_vec++; if (hazard_o !== !FWD) begin n_err++; $display("FAIL b2b_s1_hazard got %b exp %b", hazard_o, !FWD); end
        n_vec++; if (fwd2_o !== (FWD ? 2'd1 : 2'd0)) begin
            n_err++; $display("FAIL b2b_young_fwd2 got %0d exp %0d", fwd2_o, FWD ? 1 : 0); end
        clear_pipe();
        valid_D = 0; ctrl_D = 24'h000030; rd_D = 5'd5;
        step();
        valid_D = 1; ctrl_D = 24'h0; rd_D = 5'd0; rs1_D = 5'd5; reg_rd_D = 2'b01;
        #1;
        n_vec++; if (hazard_o !== 1'b0) begin n_err++; $display("FAIL inv_writer_hazard got %b exp 0", hazard_o); end
        clear_pipe();
        valid_D = 1; ctrl_D = 24'h000030; rd_D = 5'd5;
        step();
        valid_D = 0; rs1_D = 5'd5; reg_rd_D = 2'b01;
        #1;
        n_vec++; if (hazard_o !== 1'b0) begin n_err++; $display("FAIL inv_decode_hazard got %b exp 0", hazard_o); end
        idle();
    endtask

    task automatic test_x0();
        clear_pipe();
        valid_D = 1; ctrl_D = 24'h000030; rd_D = 5'd0;
        step();
        ctrl_D = 24'h000010; rd_D = 5'd3; rs1_D = 5'd0; rs2_D = 5'd0; reg_rd_D = 2'b11;
        for (int i = 0; i < 2; i++) begin
            flush_i = 3'b001;
            #1;
            n_vec++; if (hazard_o !== 1'b0) begin n_err++; $display("FAIL x0_%0d_hazard got %b exp 0", i, hazard_o); end
            n_vec++; if ({fwd1_o, fwd2_o} !== 4'b0000) begin
                n_err++; $display("FAIL x0_%0d_fwd got %b exp 0000", i, {fwd1_o, fwd2_o}); end
            step();
        end
        idle();
    endtask

    initial begin
        reset_E = 1;
        idle();
        test_reset();
        test_branch();
        test_stall();
        test_flush_stall();
        test_load_use();
        test_back_to_back();
        test_x0();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
